// File: rtl/dsp_pipe_chain.sv
// DEPTH-stage pipeline delay line with per-stage valid bits and a runtime-selectable output tap.
// LAT=0 bypasses the chain combinationally; LAT above DEPTH is treated as DEPTH.
module dsp_pipe_chain #(
  parameter int WIDTH = 18,
  parameter int DEPTH = 4,
  parameter int LATW  = $clog2(DEPTH + 1)
) (
  input  logic             CLK,
  input  logic             RST,
  input  logic             CE,
  input  logic             FLUSH,
  input  logic [LATW-1:0]  LAT,
  input  logic [WIDTH-1:0] D,
  input  logic             D_VLD,
  output logic [WIDTH-1:0] Q,
  output logic             Q_VLD,
  output logic [LATW-1:0]  CNT
);

  logic [DEPTH-1:0][WIDTH-1:0] s;
  logic [DEPTH-1:0]            v;
  logic [LATW-1:0]             eff_lat;

  // CNT tracks popcount(v) incrementally: one entry enters at s[0], one leaves from s[DEPTH-1]
  always_ff @(posedge CLK or posedge RST) begin
    if (RST) begin
      s   <= '0;
      v   <= '0;
      CNT <= '0;
    end else if (FLUSH) begin
      s   <= '0;
      v   <= '0;
      CNT <= '0;
    end else if (CE) begin
      s[0] <= D;
      v[0] <= D_VLD;
      for (int k = 1; k < DEPTH; k++) begin
        s[k] <= s[k-1];
        v[k] <= v[k-1];
      end
      CNT <= CNT + LATW'(D_VLD) - LATW'(v[DEPTH-1]);
    end
  end

  assign eff_lat = (LAT > LATW'(DEPTH)) ? LATW'(DEPTH) : LAT;

  always_comb begin
    Q     = D;
    Q_VLD = D_VLD;
    for (int k = 0; k < DEPTH; k++) begin
      if (eff_lat == LATW'(k + 1)) begin
        Q     = s[k];
        Q_VLD = v[k];
      end
    end
  end

endmodule
